// File: rtl/jelly2_img_sobel_arbiter_pkg.sv
// Shared types and constants for the Sobel datapath arbiter.
//   state_t    : arbiter state (idle / locked onto one channel's packet)
//   STAT_WIDTH : width of each statistics counter
package jelly2_img_sobel_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int unsigned STAT_WIDTH = 32;

endpackage

// File: rtl/jelly2_img_sobel_arbiter_rr.sv
// Round-robin picker: selects the first requesting channel after ptr, wrapping.
//   req   : per-channel request vector
//   ptr   : channel granted last; search starts at ptr+1
//   sel   : chosen channel (0 when nothing requests)
//   found : at least one channel requests
module jelly2_img_sobel_arbiter_rr #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CH_WIDTH = 1
) (
  input  logic [N_CH-1:0]     req,
  input  logic [CH_WIDTH-1:0] ptr,
  output logic [CH_WIDTH-1:0] sel,
  output logic                found
);

  // Smallest rotational distance from ptr+1 wins.
  always_comb begin
    int unsigned best_d;
    int unsigned d;
    sel    = '0;
    found  = 1'b0;
    best_d = N_CH;
    d      = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      d = (i + N_CH - 1 - 32'(ptr)) % N_CH;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        sel    = CH_WIDTH'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jelly2_img_sobel_arbiter.sv
// Shares one fixed-latency, cke-stalled 3x3 Sobel datapath among N_CH window
// streams. Round-robin grant that stays locked on a channel until s_last.
// Channel/last/user tags ride a LATENCY-deep shift register alongside the
// datapath and are re-joined with its result on the m_* valid/ready stream.
//   s_*        : per-channel window inputs (valid/ready, last, user, 3x3 data)
//   dp_*       : datapath clock enable, window out, result in
//   m_*        : merged result stream
//   stat_*     : grant / stall counters, built only when
//                JELLY2_IMG_SOBEL_ARBITER_STATS_EN is defined (else tied 0)
module jelly2_img_sobel_arbiter
  import jelly2_img_sobel_arbiter_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned CH_WIDTH   = $clog2(N_CH),
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GRAD_WIDTH = 10,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned LATENCY    = 5
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           cke,
  input  logic [N_CH-1:0]                s_valid,
  output logic [N_CH-1:0]                s_ready,
  input  logic [N_CH-1:0]                s_last,
  input  logic [N_CH*USER_WIDTH-1:0]     s_user,
  input  logic [N_CH*9*DATA_WIDTH-1:0]   s_data,
  output logic                           dp_cke,
  output logic [9*DATA_WIDTH-1:0]        dp_in_data,
  input  logic [DATA_WIDTH-1:0]          dp_data,
  input  logic [GRAD_WIDTH-1:0]          dp_grad_x,
  input  logic [GRAD_WIDTH-1:0]          dp_grad_y,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CH_WIDTH-1:0]            m_ch,
  output logic                           m_last,
  output logic [USER_WIDTH-1:0]          m_user,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [GRAD_WIDTH-1:0]          m_grad_x,
  output logic [GRAD_WIDTH-1:0]          m_grad_y,
  input  logic                           stat_clear,
  output logic [N_CH*STAT_WIDTH-1:0]     stat_grant,
  output logic [STAT_WIDTH-1:0]          stat_stall
);

  localparam int unsigned WIN_WIDTH = 9 * DATA_WIDTH;

  state_t                state_q, state_d;
  logic [CH_WIDTH-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIN_WIDTH-1:0]  win_q, win_d;
  logic [LATENCY-1:0]    tv_q, tv_d;
  logic [CH_WIDTH-1:0]   tch_q [LATENCY];
  logic [CH_WIDTH-1:0]   tch_d [LATENCY];
  logic                  tlast_q [LATENCY];
  logic                  tlast_d [LATENCY];
  logic [USER_WIDTH-1:0] tuser_q [LATENCY];
  logic [USER_WIDTH-1:0] tuser_d [LATENCY];

  logic                  advance;
  logic [CH_WIDTH-1:0]   rr_sel;
  logic                  rr_found;
  logic [CH_WIDTH-1:0]   sel;
  logic                  sel_ok;
  logic                  sel_valid;
  logic                  sel_last;
  logic [USER_WIDTH-1:0] sel_user;
  logic [WIN_WIDTH-1:0]  sel_data;
  logic                  xfer;

  jelly2_img_sobel_arbiter_rr #(
    .N_CH     (N_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_rr (
    .req   (s_valid),
    .ptr   (rr_ptr_q),
    .sel   (rr_sel),
    .found (rr_found)
  );

  // Result side is the last tag stage; datapath outputs pass straight through
  // and stay put while stalled because dp_cke is low.
  assign m_valid  = tv_q[LATENCY-1];
  assign m_ch     = tch_q[LATENCY-1];
  assign m_last   = tlast_q[LATENCY-1];
  assign m_user   = tuser_q[LATENCY-1];
  assign m_data   = dp_data;
  assign m_grad_x = dp_grad_x;
  assign m_grad_y = dp_grad_y;

  // Pipeline moves only when the output slot is free or being consumed.
  assign advance    = cke & (~m_valid | m_ready);
  assign dp_cke     = advance & aresetn;
  assign dp_in_data = win_d;

  // Channel select and input mux; locked channel overrides the picker.
  always_comb begin
    sel       = (state_q == ST_LOCK) ? lock_ch_q : rr_sel;
    sel_ok    = (state_q == ST_LOCK) | rr_found;
    s_ready   = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel == CH_WIDTH'(i)) begin
        sel_valid  = s_valid[i];
        sel_last   = s_last[i];
        sel_user   = s_user[i*USER_WIDTH +: USER_WIDTH];
        sel_data   = s_data[i*WIN_WIDTH +: WIN_WIDTH];
        s_ready[i] = advance & sel_ok & aresetn;
      end
    end
    xfer = sel_ok & sel_valid & advance;
  end

  // Arbiter next state, held window and tag shift.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    tv_d      = tv_q;
    tch_d     = tch_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    if (xfer) begin
      win_d = sel_data;
      if (sel_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = sel;
      end else begin
        state_d   = ST_LOCK;
        lock_ch_d = sel;
      end
    end
    if (advance) begin
      // A non-transfer advance enters a bubble (tag valid 0).
      tv_d[0]    = xfer;
      tch_d[0]   = sel;
      tlast_d[0] = sel_last;
      tuser_d[0] = sel_user;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tv_d[i]    = tv_q[i-1];
        tch_d[i]   = tch_q[i-1];
        tlast_d[i] = tlast_q[i-1];
        tuser_d[i] = tuser_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= CH_WIDTH'(N_CH - 1);
      win_q     <= '0;
      tv_q      <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tch_q[i]   <= '0;
        tlast_q[i] <= 1'b0;
        tuser_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      tv_q      <= tv_d;
      tch_q     <= tch_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
    end
  end

`ifdef JELLY2_IMG_SOBEL_ARBITER_STATS_EN
  logic [STAT_WIDTH-1:0] grant_q [N_CH];
  logic [STAT_WIDTH-1:0] grant_d [N_CH];
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // Counters freeze with cke; clear wins over increment.
  always_comb begin
    grant_d = grant_q;
    stall_d = stall_q;
    if (cke) begin
      if (stat_clear) begin
        for (int unsigned i = 0; i < N_CH; i++) grant_d[i] = '0;
        stall_d = '0;
      end else begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (xfer && (sel == CH_WIDTH'(i))) grant_d[i] = grant_q[i] + STAT_WIDTH'(1);
        end
        if (m_valid && !m_ready) stall_d = stall_q + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < N_CH; i++) grant_q[i] <= '0;
      stall_q <= '0;
    end else begin
      grant_q <= grant_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) stat_grant[i*STAT_WIDTH +: STAT_WIDTH] = grant_q[i];
  end
  assign stat_stall = stall_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_grant        = '0;
  assign stat_stall        = '0;
`endif

endmodule

// File: tb/tb_jelly2_img_sobel_arbiter.sv
// Scoreboard bench for jelly2_img_sobel_arbiter with a behavioural 5-stage
// Sobel datapath. Expected results are pushed in hand-derived grant order;
// a separate monitor pops and compares on every m_valid & m_ready.
module tb_jelly2_img_sobel_arbiter;

  localparam int unsigned N_CH = 2;
  localparam int unsigned CHW  = 1;
  localparam int unsigned DW   = 8;
  localparam int unsigned GW   = 11;
  localparam int unsigned UW   = 1;
  localparam int unsigned LAT  = 5;
  localparam int unsigned WW   = 9 * DW;

  logic                   clk = 1'b0;
  logic                   aresetn, cke;
  logic [N_CH-1:0]        s_valid, s_ready, s_last;
  logic [N_CH*UW-1:0]     s_user;
  logic [N_CH*WW-1:0]     s_data;
  logic                   dp_cke;
  logic [WW-1:0]          dp_in_data;
  logic [DW-1:0]          dp_data;
  logic signed [GW-1:0]   dp_grad_x, dp_grad_y;
  logic                   m_valid, m_ready, m_last;
  logic [CHW-1:0]         m_ch;
  logic [UW-1:0]          m_user;
  logic [DW-1:0]          m_data;
  logic signed [GW-1:0]   m_grad_x, m_grad_y;
  logic                   stat_clear;
  logic [N_CH*32-1:0]     stat_grant;
  logic [31:0]            stat_stall;

  always #5 clk = ~clk;

  jelly2_img_sobel_arbiter #(
    .N_CH(N_CH), .CH_WIDTH(CHW), .DATA_WIDTH(DW), .GRAD_WIDTH(GW),
    .USER_WIDTH(UW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .aresetn(aresetn), .cke(cke),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_user(s_user), .s_data(s_data),
    .dp_cke(dp_cke), .dp_in_data(dp_in_data), .dp_data(dp_data),
    .dp_grad_x(dp_grad_x), .dp_grad_y(dp_grad_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_last(m_last), .m_user(m_user),
    .m_data(m_data), .m_grad_x(m_grad_x), .m_grad_y(m_grad_y),
    .stat_clear(stat_clear), .stat_grant(stat_grant), .stat_stall(stat_stall)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
    logic [UW-1:0] user;
  } src_t;

  typedef struct {
    logic [CHW-1:0]       ch;
    logic                 last;
    logic [UW-1:0]        user;
    logic [DW-1:0]        data;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
  } exp_t;

  src_t src0[$];
  src_t src1[$];
  exp_t exp_q[$];
  bit   gap0 = 1'b0;
  int   cyc = 0;
  int   first_acc = -1;
  int   first_mv = -1;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] px(input logic [WW-1:0] w, input int r, input int c);
    return w[(r*3+c)*DW +: DW];
  endfunction

  // Horizontal gradient: left column minus right column.
  function automatic logic signed [GW-1:0] sob_x(input logic [WW-1:0] w);
    int s;
    s = int'(px(w,0,0)) + 2*int'(px(w,1,0)) + int'(px(w,2,0))
      - int'(px(w,0,2)) - 2*int'(px(w,1,2)) - int'(px(w,2,2));
    return GW'(s);
  endfunction

  // Vertical gradient: top row minus bottom row.
  function automatic logic signed [GW-1:0] sob_y(input logic [WW-1:0] w);
    int s;
    s = int'(px(w,0,0)) + 2*int'(px(w,0,1)) + int'(px(w,0,2))
      - int'(px(w,2,0)) - 2*int'(px(w,2,1)) - int'(px(w,2,2));
    return GW'(s);
  endfunction

  function automatic logic [WW-1:0] mk_win(input int ch, input int k);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*DW +: DW] = DW'((ch*50 + k*37 + r*13 + c*29) % 256);
    return w;
  endfunction

  // Behavioural datapath: LAT stages advancing on dp_cke.
  logic [DW-1:0]        dpd [LAT];
  logic signed [GW-1:0] dpx [LAT];
  logic signed [GW-1:0] dpy [LAT];
  always @(posedge clk) begin
    if (dp_cke) begin
      dpd[0] <= px(dp_in_data, 1, 1);
      dpx[0] <= sob_x(dp_in_data);
      dpy[0] <= sob_y(dp_in_data);
      for (int i = 1; i < LAT; i++) begin
        dpd[i] <= dpd[i-1];
        dpx[i] <= dpx[i-1];
        dpy[i] <= dpy[i-1];
      end
    end
  end
  assign dp_data   = dpd[LAT-1];
  assign dp_grad_x = dpx[LAT-1];
  assign dp_grad_y = dpy[LAT-1];

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_src(input int ch, input int k, input logic last, input logic [UW-1:0] user);
    src_t s;
    s.win = mk_win(ch, k); s.last = last; s.user = user;
    if (ch == 0) src0.push_back(s); else src1.push_back(s);
  endtask

  task automatic push_exp(input int ch, input logic last, input logic [UW-1:0] user,
                          input logic [DW-1:0] data, input logic signed [GW-1:0] gx,
                          input logic signed [GW-1:0] gy);
    exp_t e;
    e.ch = CHW'(ch); e.last = last; e.user = user; e.data = data; e.gx = gx; e.gy = gy;
    exp_q.push_back(e);
  endtask

  task automatic expect_win(input int ch, input int k, input logic last, input logic [UW-1:0] user);
    logic [WW-1:0] w;
    w = mk_win(ch, k);
    push_exp(ch, last, user, px(w,1,1), sob_x(w), sob_y(w));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    chk(nm, (src0.size() == 0 && src1.size() == 0 && exp_q.size() == 0) ? 1 : 0, 1);
    repeat (LAT + 2) tick();
  endtask

  // Source driver: presents queue heads, pops on handshake just before the edge.
  initial begin
    s_valid = '0; s_last = '0; s_user = '0; s_data = '0;
    forever begin
      @(negedge clk);
      s_valid[0] = (src0.size() > 0) && !gap0;
      if (src0.size() > 0) begin
        s_data[0 +: WW] = src0[0].win; s_last[0] = src0[0].last; s_user[0 +: UW] = src0[0].user;
      end
      s_valid[1] = (src1.size() > 0);
      if (src1.size() > 0) begin
        s_data[WW +: WW] = src1[0].win; s_last[1] = src1[0].last; s_user[UW +: UW] = src1[0].user;
      end
      #4;
      if (s_valid[0] && s_ready[0]) begin
        void'(src0.pop_front());
        if (first_acc < 0) first_acc = cyc;
      end
      if (s_valid[1] && s_ready[1]) begin
        void'(src1.pop_front());
        if (first_acc < 0) first_acc = cyc;
      end
    end
  end

  // Result monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (m_valid === 1'b1 && first_mv < 0) first_mv = cyc;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_ch",   longint'(m_ch),     longint'(e.ch));
          chk("res_last", longint'(m_last),   longint'(e.last));
          chk("res_user", longint'(m_user),   longint'(e.user));
          chk("res_data", longint'(m_data),   longint'(e.data));
          chk("res_gx",   longint'(m_grad_x), longint'(e.gx));
          chk("res_gy",   longint'(m_grad_y), longint'(e.gy));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blocked, gap_left, t_a, t_b, n;
    bit gap_started;
    logic [CHW-1:0]       snap_ch;
    logic [DW-1:0]        snap_d;
    logic signed [GW-1:0] snap_x;
    logic [WW-1:0]        w;
    src_t                 s;

    aresetn = 1'b0; cke = 1'b1; m_ready = 1'b1; stat_clear = 1'b0;
    tick();

    // Test 1 sources presented while still in reset.
    for (int k = 0; k < 4; k++) begin
      add_src(0, k, 1'b1, 1'b0);
      add_src(1, k, 1'b1, 1'b1);
    end
    tick();
    chk("rst_s_ready", longint'(s_ready), 0);
    chk("rst_dp_cke",  longint'(dp_cke),  0);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_m_ch",    longint'(m_ch),    0);
    chk("rst_m_last",  longint'(m_last),  0);
    chk("rst_m_user",  longint'(m_user),  0);
    for (int k = 0; k < 4; k++) begin
      expect_win(0, k, 1'b1, 1'b0);
      expect_win(1, k, 1'b1, 1'b1);
    end
    aresetn = 1'b1;
    drain("t1_drain");
    chk("t1_latency", first_mv - first_acc, LAT);

    // Test 2: ch0 4-window packet holds the lock against ch1.
    for (int k = 10; k < 14; k++) add_src(0, k, k == 13, 1'b0);
    add_src(1, 10, 1'b1, 1'b1);
    add_src(1, 11, 1'b1, 1'b1);
    for (int k = 10; k < 14; k++) expect_win(0, k, k == 13, 1'b0);
    expect_win(1, 10, 1'b1, 1'b1);
    expect_win(1, 11, 1'b1, 1'b1);
    blocked = 0; n = 0;
    while (src0.size() > 0 && n < 200) begin
      tick(); n++;
      if (src0.size() > 0 && s_ready[1]) blocked++;
    end
    chk("t2_ch1_blocked", blocked, 0);
    drain("t2_drain");

    // Test 3: back-pressure with a full pipe.
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    for (int k = 20; k < 24; k++) begin
      add_src(0, k, 1'b1, 1'b1);
      add_src(1, k, 1'b1, 1'b0);
      expect_win(0, k, 1'b1, 1'b1);
      expect_win(1, k, 1'b1, 1'b0);
    end
    m_ready = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin tick(); n++; end
    chk("t3_fill", longint'(m_valid), 1);
    snap_ch = m_ch; snap_d = m_data; snap_x = m_grad_x;
    for (int i = 0; i < 10; i++) begin
      chk("t3_dp_cke",  longint'(dp_cke),   0);
      chk("t3_s_ready", longint'(s_ready),  0);
      chk("t3_m_valid", longint'(m_valid),  1);
      chk("t3_m_ch",    longint'(m_ch),     longint'(snap_ch));
      chk("t3_m_data",  longint'(m_data),   longint'(snap_d));
      chk("t3_m_gx",    longint'(m_grad_x), longint'(snap_x));
      tick();
    end
    m_ready = 1'b1;
`ifdef JELLY2_IMG_SOBEL_ARBITER_STATS_EN
    chk("t3_stat_stall", longint'(stat_stall), 10);
`endif
    drain("t3_drain");
`ifdef JELLY2_IMG_SOBEL_ARBITER_STATS_EN
    chk("t3_stat_grant0", longint'(stat_grant[31:0]),  4);
    chk("t3_stat_grant1", longint'(stat_grant[63:32]), 4);
`endif

    // Test 4: locked ch0 drops valid for 3 cycles mid-packet.
    for (int k = 30; k < 36; k++) add_src(0, k, k == 35, 1'b0);
    add_src(1, 30, 1'b1, 1'b1);
    add_src(1, 31, 1'b1, 1'b1);
    for (int k = 30; k < 36; k++) expect_win(0, k, k == 35, 1'b0);
    expect_win(1, 30, 1'b1, 1'b1);
    expect_win(1, 31, 1'b1, 1'b1);
    blocked = 0; n = 0; gap_left = 0; gap_started = 1'b0; t_a = -1; t_b = -1;
    while (src0.size() > 0 && n < 200) begin
      tick(); n++;
      if (src0.size() > 0 && s_ready[1]) blocked++;
      if (src0.size() == 4 && !gap_started) begin
        gap0 = 1'b1; gap_started = 1'b1; gap_left = 3; t_a = cyc;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) gap0 = 1'b0;
      end
      if (src0.size() == 3 && t_b < 0) t_b = cyc;
    end
    gap0 = 1'b0;
    chk("t4_ch1_blocked", blocked, 0);
    chk("t4_gap_cycles", t_b - t_a, 4);
    drain("t4_drain");

    // Test 5: reset mid-packet; ch0 must win first afterwards.
    add_src(0, 40, 1'b1, 1'b0);
    expect_win(0, 40, 1'b1, 1'b0);
    drain("t5_pre_drain");
    for (int k = 41; k < 45; k++) add_src(1, k, k == 44, 1'b1);
    n = 0;
    while (src1.size() > 2 && n < 100) begin tick(); n++; end
    chk("t5_ch1_started", src1.size(), 2);
    aresetn = 1'b0;
    #1;
    chk("t5_m_valid", longint'(m_valid), 0);
    chk("t5_s_ready", longint'(s_ready), 0);
    chk("t5_dp_cke",  longint'(dp_cke),  0);
    src1.delete();
    exp_q.delete();
    tick();
    chk("t5_m_valid_edge", longint'(m_valid), 0);
    chk("t5_m_ch", longint'(m_ch), 0);
`ifdef JELLY2_IMG_SOBEL_ARBITER_STATS_EN
    chk("t5_stat_grant0", longint'(stat_grant[31:0]), 0);
    chk("t5_stat_stall",  longint'(stat_stall), 0);
`endif
    tick();
    aresetn = 1'b1;
    add_src(1, 45, 1'b1, 1'b1);
    add_src(0, 46, 1'b1, 1'b0);
    expect_win(0, 46, 1'b1, 1'b0);
    expect_win(1, 45, 1'b1, 1'b1);
    drain("t5_drain");

    // Test 6: known windows with hand-computed gradients.
    w = '0;
    for (int r = 0; r < 3; r++) begin
      w[(r*3+0)*DW +: DW] = 8'd0;
      w[(r*3+1)*DW +: DW] = 8'd128;
      w[(r*3+2)*DW +: DW] = 8'd255;
    end
    s.win = w; s.last = 1'b1; s.user = 1'b1;
    src1.push_back(s);
    w = '0;
    for (int c = 0; c < 3; c++) begin
      w[(0*3+c)*DW +: DW] = 8'd255;
      w[(1*3+c)*DW +: DW] = 8'd100;
      w[(2*3+c)*DW +: DW] = 8'd0;
    end
    s.win = w; s.last = 1'b1; s.user = 1'b0;
    src0.push_back(s);
    push_exp(0, 1'b1, 1'b0, 8'd100, 11'sd0, 11'sd1020);
    push_exp(1, 1'b1, 1'b1, 8'd128, -11'sd1020, 11'sd0);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
